// File: rtl/rng_pkg.sv
// Shared types and helpers for the rng_arbiter entropy-sharing block:
// FSM state encoding, word folding and round-robin winner selection.
package rng_pkg;

  localparam int STUCK_LIMIT_DEF = 64;
  localparam int FOLD_MAX_N      = 256;
  localparam int FOLD_IW         = 8;
  localparam int IDX_W           = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    GRANT  = 2'd2
  } state_e;

  // Bit i of the bus lands in word bit i mod w, which is the XOR of the
  // zero-padded w-bit chunks.
  function automatic logic [FOLD_MAX_N-1:0] fold(input logic [FOLD_MAX_N-1:0] s,
                                                 input int n, input int w);
    logic [FOLD_MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < FOLD_MAX_N; i++) begin
      if (i < n) r[FOLD_IW'(i % w)] = r[FOLD_IW'(i % w)] ^ s[i];
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] rr_pick(input logic [7:0] req,
                                               input logic [IDX_W-1:0] ptr,
                                               input int nreq);
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (k < nreq && !found && req[IDX_W'(idx)]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] win,
                                                input int nreq);
    return IDX_W'((int'(win) + 1) % nreq);
  endfunction

endpackage

// File: rtl/rng_arbiter_if.sv
// Requester-side handshake bundle of rng_arbiter: level requests in,
// one-hot ack pulses, the random word and the stuck-source flag out.
interface rng_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [W-1:0]    rnd_out;
  logic            fault;

  modport master (output req, input ack, input rnd_out, input fault);
  modport slave  (input req, output ack, output rnd_out, output fault);
endinterface

// File: rtl/rng_sync.sv
// N-bit two-flop synchronizer bank bringing the free-running entropy bus
// into the clk_sys domain; cleared asynchronously by reset_n.
module rng_sync #(
  parameter int N = 63
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin sharer of the lfsr entropy bus with rotate-XOR conditioning.
// Define RNG_HEALTH_EN to enable the stuck-source monitor and fault blocking.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int N           = 63,
  parameter int W           = 16,
  parameter int NREQ        = 4,
  parameter int FOLD_CYC    = 4,
  parameter int STUCK_LIMIT = STUCK_LIMIT_DEF
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic [N-1:0] ent_in,
  rng_arbiter_if.slave bus
);

  localparam int CW = (FOLD_CYC > 1) ? $clog2(FOLD_CYC) : 1;

  logic [N-1:0]     s;
  logic [W-1:0]     fold_w;
  logic             fault;
  state_e           state;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] ptr;
  logic [W-1:0]     acc;
  logic [W-1:0]     held;
  logic [CW-1:0]    cnt;
  logic [7:0]       req8;
  logic             grant_ok;

  rng_sync #(.N(N)) u_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d       (ent_in),
    .q       (s)
  );

  assign fold_w = W'(fold(FOLD_MAX_N'(s), N, W));

`ifdef RNG_HEALTH_EN
  localparam int SW = $clog2(STUCK_LIMIT + 1);

  logic [N-1:0]  prev;
  logic [SW-1:0] stuck;

  // Counts consecutive identical samples, saturating at the limit.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev  <= '0;
      stuck <= '0;
    end else begin
      prev <= s;
      if (s != prev)                      stuck <= '0;
      else if (stuck != SW'(STUCK_LIMIT)) stuck <= stuck + 1'b1;
    end
  end

  assign fault = (stuck == SW'(STUCK_LIMIT));
`else
  assign fault = 1'b0;
`endif

  assign bus.fault = fault;

  always_comb begin
    req8            = '0;
    req8[NREQ-1:0]  = bus.req;
  end

  assign grant_ok = (state == GRANT) && req8[win] && !fault;

  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDX_W'(i)) bus.ack[i] = grant_ok;
    end
  end

  // The word is driven straight from acc in the grant cycle so a consumer
  // sees it alongside ack; otherwise the last granted word is held.
  assign bus.rnd_out = grant_ok ? acc : held;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      win   <= '0;
      ptr   <= '0;
      acc   <= '0;
      cnt   <= '0;
      held  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|bus.req) && !fault) begin
            win   <= rr_pick(req8, ptr, NREQ);
            acc   <= '0;
            cnt   <= '0;
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (fault) begin
            state <= IDLE;
          end else begin
            acc <= ((acc << 1) | (acc >> (W - 1))) ^ fold_w;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(FOLD_CYC - 1)) state <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ok) begin
            ptr  <= next_ptr(win, NREQ);
            held <= acc;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a transaction-level model.
module tb_rng_arbiter;

  localparam int N    = 63;
  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int F    = 4;
  localparam int LIM  = 64;
  localparam int PADW = ((N + W - 1) / W) * W;
  localparam logic [N-1:0] ALL1 = '1;

  logic         clk_sys = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] ent_in  = '1;

  rng_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  rng_arbiter #(
    .N(N), .W(W), .NREQ(NREQ), .FOLD_CYC(F), .STUCK_LIMIT(LIM)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ent_in  (ent_in),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N-1:0]    m_sync1, m_sync2;
  int              m_stage;
  int              m_win, m_ptr;
  logic [W-1:0]    m_samples[$];
  logic [W-1:0]    m_held;
`ifdef RNG_HEALTH_EN
  logic [N-1:0]    m_prev;
  int              m_stuck;
`endif

  logic [NREQ-1:0] obs_ack, exp_ack;
  logic [W-1:0]    obs_rnd;
  logic            obs_fault;
  bit              rec;
  int              cyc;
  int              ack_cyc[$];
  logic [NREQ-1:0] ack_val[$];

  function automatic logic [W-1:0] ref_fold(input logic [N-1:0] s);
    logic [PADW-1:0] padded;
    logic [W-1:0]    r;
    padded = PADW'(s);
    r = '0;
    for (int k = 0; k < PADW / W; k++) r = r ^ padded[k*W +: W];
    return r;
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    return (v << n) | (v >> (W - n));
  endfunction

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] wv;
    wv = '0;
    for (int j = 0; j < m_samples.size(); j++) wv = wv ^ rotl(m_samples[j], F - 1 - j);
    return wv;
  endfunction

  function automatic bit model_fault();
`ifdef RNG_HEALTH_EN
    return m_stuck == LIM;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_sync1 = '0; m_sync2 = '0; m_stage = -1; m_win = 0; m_ptr = 0;
    m_samples.delete(); m_held = '0;
`ifdef RNG_HEALTH_EN
    m_prev = '0; m_stuck = 0;
`endif
  endtask

  task automatic model_edge(input logic [NREQ-1:0] r, input logic [N-1:0] e);
    bit           f;
    bit           found;
    logic [N-1:0] s;
    f = model_fault();
    s = m_sync2;
    if (m_stage < 0) begin
      if (r != 0 && !f) begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && r[(m_ptr + k) % NREQ]) begin
            m_win = (m_ptr + k) % NREQ;
            found = 1;
          end
        end
        m_samples.delete();
        m_stage = 0;
      end
    end else if (m_stage < F) begin
      if (f) m_stage = -1;
      else begin
        m_samples.push_back(ref_fold(s));
        m_stage++;
      end
    end else begin
      if (r[m_win] && !f) begin
        m_held = model_word();
        m_ptr  = (m_win + 1) % NREQ;
      end
      m_stage = -1;
    end
`ifdef RNG_HEALTH_EN
    if (s != m_prev) m_stuck = 0;
    else if (m_stuck < LIM) m_stuck++;
    m_prev = s;
`endif
    m_sync2 = m_sync1;
    m_sync1 = e;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic check_output();
    logic [W-1:0] e_rnd;
    logic         e_fault;
    exp_ack = '0;
    if (!reset_n) begin
      e_rnd   = '0;
      e_fault = 1'b0;
    end else begin
      e_fault = model_fault();
      if (m_stage == F && bus.req[m_win] && !e_fault) exp_ack[m_win] = 1'b1;
      e_rnd = (exp_ack != 0) ? model_word() : m_held;
    end
    obs_ack   = bus.ack;
    obs_rnd   = bus.rnd_out;
    obs_fault = bus.fault;
    check_val("ack", 32'(obs_ack), 32'(exp_ack));
    check_val("rnd_out", 32'(obs_rnd), 32'(e_rnd));
    check_val("fault", 32'(obs_fault), 32'(e_fault));
    if (rec && obs_ack != 0) begin
      ack_cyc.push_back(cyc);
      ack_val.push_back(obs_ack);
    end
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] r, input logic [N-1:0] e,
                                input logic rst_n_v);
    @(negedge clk_sys);
    bus.req = r;
    ent_in  = e;
    reset_n = rst_n_v;
    #1;
    check_output();
    cyc++;
    @(posedge clk_sys);
    if (!reset_n) model_reset();
    else model_edge(r, e);
  endtask

  function automatic logic [N-1:0] rand_ent();
    return N'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset(input logic [N-1:0] e);
    apply_stimulus('0, e, 1'b0);
    apply_stimulus('0, e, 1'b0);
  endtask

  initial begin
    logic [NREQ-1:0] pend;
    logic [N-1:0]    ent, e2;
    int              nack;

    model_reset();
    bus.req = '0;
    rec = 0;
    cyc = 0;

    // Reset values
    do_reset(ALL1);
    check_val("reset_ack", 32'(obs_ack), 0);
    check_val("reset_rnd", 32'(obs_rnd), 0);
    check_val("reset_fault", 32'(obs_fault), 0);

    // Fold value with constant all-ones entropy
    for (int c = 0; c < 12; c++) begin
      apply_stimulus((c >= 5 && c <= 10) ? 4'b0001 : 4'b0000, ALL1, 1'b1);
      if (c == 9) check_val("fold_early", 32'(obs_ack), 0);
      if (c == 10) begin
        check_val("fold_ack", 32'(obs_ack), 32'h1);
        check_val("fold_word", 32'(obs_rnd), 32'h8007);
      end
    end

    // Round-robin with all requests held
    do_reset(rand_ent());
    ack_cyc.delete(); ack_val.delete();
    rec = 1;
    for (int c = 0; c < 32; c++) apply_stimulus(4'b1111, rand_ent(), 1'b1);
    rec = 0;
    check_val("rr_count", 32'(ack_val.size() >= 5), 1);
    for (int i = 0; i < 5 && i < ack_val.size(); i++) begin
      check_val("rr_order", 32'(ack_val[i]), 32'(1 << (i % NREQ)));
      check_val("rr_onehot", 32'($onehot(ack_val[i])), 1);
      if (i > 0) check_val("rr_spacing", ack_cyc[i] - ack_cyc[i-1], F + 2);
    end

    // Withdrawal during SAMPLE
    do_reset(rand_ent());
    nack = 0;
    for (int c = 0; c < 13; c++) begin
      apply_stimulus((c < 3) ? 4'b0100 : 4'b0000, rand_ent(), 1'b1);
      if (obs_ack != 0) nack++;
    end
    check_val("withdraw_noack", nack, 0);
    ack_cyc.delete(); ack_val.delete();
    rec = 1;
    pend = 4'b1101;
    for (int c = 0; c < 40 && pend != 0; c++) begin
      apply_stimulus(pend, rand_ent(), 1'b1);
      pend = pend & ~exp_ack;
    end
    rec = 0;
    check_val("withdraw_count", ack_val.size(), 3);
    if (ack_val.size() == 3) begin
      check_val("withdraw_ptr", 32'(ack_val[0]), 32'h1);
      check_val("withdraw_regrant", 32'(ack_val[1]), 32'h4);
    end

    // Reset asserted mid-SAMPLE
    for (int c = 0; c < 3; c++) apply_stimulus(4'b0010, rand_ent(), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_val("midrst_ack", 32'(bus.ack), 0);
    check_val("midrst_rnd", 32'(bus.rnd_out), 0);
    apply_stimulus(4'b0010, rand_ent(), 1'b0);
    apply_stimulus(4'b0010, rand_ent(), 1'b0);
    for (int c = 0; c < 7; c++) begin
      apply_stimulus((c <= 5) ? 4'b0010 : 4'b0000, rand_ent(), 1'b1);
      if (c == 4) check_val("midrst_early", 32'(obs_ack), 0);
      if (c == 5) check_val("midrst_latency", 32'(obs_ack), 32'h2);
    end

    // Stuck source with req[1] held
    do_reset(ALL1);
    nack = 0;
    for (int c = 0; c < 80; c++) begin
      apply_stimulus(4'b0010, ALL1, 1'b1);
      if (c >= 70 && obs_ack != 0) nack++;
    end
`ifdef RNG_HEALTH_EN
    check_val("health_fault_set", 32'(obs_fault), 1);
    check_val("health_starve", nack, 0);
`else
    check_val("health_fault_off", 32'(obs_fault), 0);
    check_val("health_grants_continue", 32'(nack > 0), 1);
`endif
    e2 = ALL1 ^ N'(1);
    for (int c = 0; c < 10; c++) begin
      apply_stimulus(4'b0010, e2, 1'b1);
      if (c == 3) check_val("health_fault_clear", 32'(obs_fault), 0);
`ifdef RNG_HEALTH_EN
      if (c == 8) check_val("health_resume_ack", 32'(obs_ack), 32'h2);
`endif
    end

    // Random traffic
    do_reset(rand_ent());
    pend = '0;
    ent  = rand_ent();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          if ($urandom_range(15) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(3) == 0) pend[i] = 1'b1;
      end
      if ($urandom_range(3) != 0) ent = rand_ent();
      apply_stimulus(pend, ent, 1'b1);
      pend = pend & ~exp_ack;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
